// File: rtl/conv1d_pe_stream.sv
`default_nettype none
// ============================================================================
// conv1d_pe_stream : streaming 1-D convolution PE with a loadable kernel,
//                    partial-sum chaining and valid/ready handshakes.
// Revision 1.0
// ============================================================================
module conv1d_pe_stream #(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 8,
    parameter int ACC_W      = 24,
    parameter int KERNEL_LEN = 3,
    parameter int SHIFT      = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              kernel_wr,
    input  logic [$clog2(KERNEL_LEN)-1:0]     kernel_idx,
    input  logic signed [DATA_W-1:0]          kernel_data,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_W-1:0]          ifmap_in,
    input  logic signed [OUT_W-1:0]           partial_sum_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [OUT_W-1:0]           output_sum,
    output logic                              primed
);

    localparam int IDX_W  = $clog2(KERNEL_LEN);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(KERNEL_LEN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         fill_cnt;
    logic signed [DATA_W-1:0] weight   [KERNEL_LEN];
    logic signed [DATA_W-1:0] win      [KERNEL_LEN];
    logic signed [DATA_W-1:0] win_next [KERNEL_LEN];
    logic signed [ACC_W-1:0]  tap_ext  [KERNEL_LEN];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  res;
    logic signed [OUT_W-1:0]  sat;
    logic                     accept;
    logic                     produce;

    // Single-entry output register: accept new work only if it is empty or draining now.
    assign in_ready = rst && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign produce  = accept && ((state == ST_RUN) || (fill_cnt == FILL_LAST));
    assign primed   = (state == ST_RUN);

    // The output uses the window as it will look after this accept's shift.
    for (genvar k = 0; k < KERNEL_LEN; k++) begin : g_tap
        logic signed [PROD_W-1:0] w_ext;
        logic signed [PROD_W-1:0] x_ext;
        logic signed [PROD_W-1:0] prod;

        if (k == KERNEL_LEN - 1) begin : g_newest
            assign win_next[k] = ifmap_in;
        end else begin : g_shift
            assign win_next[k] = win[k+1];
        end

        assign w_ext      = {{DATA_W{weight[k][DATA_W-1]}}, weight[k]};
        assign x_ext      = {{DATA_W{win_next[k][DATA_W-1]}}, win_next[k]};
        assign prod       = w_ext * x_ext;
        assign tap_ext[k] = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    always_comb begin
        acc = {{(ACC_W-OUT_W){partial_sum_in[OUT_W-1]}}, partial_sum_in};
        for (int k = 0; k < KERNEL_LEN; k++) begin
            acc = acc + tap_ext[k];
        end
        res = acc >>> SHIFT;
        if (res > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (res < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end else begin
            sat = res[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_FILL;
            fill_cnt   <= '0;
            out_valid  <= 1'b0;
            output_sum <= '0;
            for (int k = 0; k < KERNEL_LEN; k++) begin
                weight[k] <= '0;
                win[k]    <= '0;
            end
        end else begin
            // Indices beyond KERNEL_LEN-1 match no tap and are dropped.
            for (int k = 0; k < KERNEL_LEN; k++) begin
                if (kernel_wr && (kernel_idx == IDX_W'(k))) begin
                    weight[k] <= kernel_data;
                end
            end

            if (flush) begin
                state    <= ST_FILL;
                fill_cnt <= '0;
                for (int k = 0; k < KERNEL_LEN; k++) begin
                    win[k] <= '0;
                end
            end else if (accept) begin
                for (int k = 0; k < KERNEL_LEN; k++) begin
                    win[k] <= win_next[k];
                end
                if (state == ST_FILL) begin
                    if (fill_cnt == FILL_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
            end

            if (produce) begin
                out_valid  <= 1'b1;
                output_sum <= sat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
